// File: rtl/dmem_access_seq_pkg.sv
// Shared types for the MEM-stage data-memory sequencer.
//   lc3b_word        : 16-bit data/address word
//   lc3b_opcode      : LC-3b 4-bit opcodes
//   dmem_seq_state_t : sequencer FSM states
//   is_mem_op()      : opcode touches data memory
//   is_indirect()    : opcode needs a pointer fetch before the real access
package dmem_access_seq_pkg;

  localparam int unsigned DataWidth = 16;

  typedef logic [DataWidth-1:0] lc3b_word;

  typedef enum logic [3:0] {
    op_br   = 4'b0000,
    op_add  = 4'b0001,
    op_ldb  = 4'b0010,
    op_stb  = 4'b0011,
    op_jsr  = 4'b0100,
    op_and  = 4'b0101,
    op_ldr  = 4'b0110,
    op_str  = 4'b0111,
    op_rti  = 4'b1000,
    op_not  = 4'b1001,
    op_ldi  = 4'b1010,
    op_sti  = 4'b1011,
    op_jmp  = 4'b1100,
    op_shf  = 4'b1101,
    op_lea  = 4'b1110,
    op_trap = 4'b1111
  } lc3b_opcode;

  typedef enum logic [1:0] {IDLE, ACC1, ACC2, DONE} dmem_seq_state_t;

  function automatic logic is_mem_op(lc3b_opcode op);
    return (op == op_ldr) || (op == op_ldb) || (op == op_ldi) || (op == op_str) ||
           (op == op_stb) || (op == op_sti) || (op == op_trap);
  endfunction

  function automatic logic is_indirect(lc3b_opcode op);
    return (op == op_ldi) || (op == op_sti);
  endfunction

endpackage

// File: rtl/dmem_access_seq_if.sv
// Data-memory bus between the sequencer (master) and memory (slave).
//   dmem_read/dmem_write : request strobes, held until dmem_resp
//   dmem_address         : word-aligned access address
//   dmem_wdata           : write data
//   dmem_byte_enable     : {hi,lo} write lane enables
//   dmem_resp            : access completes this cycle
//   dmem_rdata           : read data, valid with dmem_resp
interface dmem_access_seq_if;
  import dmem_access_seq_pkg::*;

  logic       dmem_read;
  logic       dmem_write;
  lc3b_word   dmem_address;
  lc3b_word   dmem_wdata;
  logic [1:0] dmem_byte_enable;
  logic       dmem_resp;
  lc3b_word   dmem_rdata;

  modport master (
    output dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable,
    input  dmem_resp, dmem_rdata
  );

  modport slave (
    input  dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable,
    output dmem_resp, dmem_rdata
  );

endinterface

// File: rtl/dmem_access_seq_byte_lane.sv
// Byte-lane steering for byte loads/stores (purely combinational).
//   addr_lsb   in  : byte select (1 = high byte)
//   rdata      in  : memory read word
//   wdata_lo   in  : low byte of the store source register
//   ldb_data   out : selected byte, zero-extended
//   stb_wdata  out : store byte replicated onto both lanes
//   stb_be     out : lane enable for the selected byte
module dmem_access_seq_byte_lane
  import dmem_access_seq_pkg::*;
(
  input  logic       addr_lsb,
  input  lc3b_word   rdata,
  input  logic [7:0] wdata_lo,
  output lc3b_word   ldb_data,
  output lc3b_word   stb_wdata,
  output logic [1:0] stb_be
);

  assign ldb_data  = {8'h00, (addr_lsb ? rdata[15:8] : rdata[7:0])};
  assign stb_wdata = {wdata_lo, wdata_lo};
  assign stb_be    = addr_lsb ? 2'b10 : 2'b01;

endmodule

// File: rtl/dmem_access_seq.sv
// MEM-stage data-memory sequencer: runs one or two handshaked dmem accesses for
// LDR/LDB/LDI/STR/STB/STI/TRAP, returns load data and stalls the pipeline while busy.
//   clk, rst_n       : clock, synchronous active-low reset
//   req_*            : MEM-stage instruction (held stable while mem_stall=1)
//   dmem             : data-memory bus (master side), outputs registered
//   mem_stall        : freeze stages at and before MEM
//   done             : one-cycle pulse when the memory op completes
//   result           : last load/trap data
module dmem_access_seq
  import dmem_access_seq_pkg::*;
#(
  parameter int unsigned DW = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  input  lc3b_opcode          req_opcode,
  input  logic [DW-1:0]       req_addr,
  input  logic [DW-1:0]       req_wdata,
  dmem_access_seq_if.master   dmem,
  output logic                mem_stall,
  output logic                done,
  output logic [DW-1:0]       result
);

  dmem_seq_state_t state_q;
  lc3b_opcode      op_q;
  logic            addr_lsb_q;
  logic [DW-1:0]   wdata_q;
  logic [DW-2:0]   ptr_q;
  logic            read_q, write_q, done_q;
  logic [DW-1:0]   address_q, dwdata_q, result_q;
  logic [1:0]      be_q;

  logic            mem_op;
  logic            lane_lsb;
  lc3b_word        ldb_data, stb_wdata;
  logic [1:0]      stb_be;

  assign mem_op    = req_valid & is_mem_op(req_opcode);
  assign mem_stall = mem_op & (state_q != DONE);

  // Stores are issued straight from the request in IDLE; byte loads use the captured lsb.
  assign lane_lsb = (state_q == IDLE) ? req_addr[0] : addr_lsb_q;

  dmem_access_seq_byte_lane u_byte_lane (
    .addr_lsb  (lane_lsb),
    .rdata     (dmem.dmem_rdata),
    .wdata_lo  (req_wdata[7:0]),
    .ldb_data  (ldb_data),
    .stb_wdata (stb_wdata),
    .stb_be    (stb_be)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_q       <= op_br;
      addr_lsb_q <= 1'b0;
      wdata_q    <= '0;
      ptr_q      <= '0;
      read_q     <= 1'b0;
      write_q    <= 1'b0;
      address_q  <= '0;
      dwdata_q   <= '0;
      be_q       <= 2'b00;
      done_q     <= 1'b0;
      result_q   <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (mem_op) begin
            state_q    <= ACC1;
            op_q       <= req_opcode;
            addr_lsb_q <= req_addr[0];
            wdata_q    <= req_wdata;
            address_q  <= {req_addr[DW-1:1], 1'b0};
            if (req_opcode == op_str) begin
              write_q  <= 1'b1;
              dwdata_q <= req_wdata;
              be_q     <= 2'b11;
            end else if (req_opcode == op_stb) begin
              write_q  <= 1'b1;
              dwdata_q <= stb_wdata;
              be_q     <= stb_be;
            end else begin
              // Loads, trap, and the pointer fetch of ldi/sti.
              read_q <= 1'b1;
              be_q   <= 2'b11;
            end
          end
        end
        ACC1: begin
          if (dmem.dmem_resp) begin
            read_q  <= 1'b0;
            write_q <= 1'b0;
            if (is_indirect(op_q)) begin
              ptr_q   <= dmem.dmem_rdata[DW-1:1];
              state_q <= ACC2;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
              if ((op_q == op_ldr) || (op_q == op_trap)) result_q <= dmem.dmem_rdata;
              else if (op_q == op_ldb) result_q <= ldb_data;
            end
          end
        end
        ACC2: begin
          // First ACC2 cycle is a bubble that launches the second access.
          if (!read_q && !write_q) begin
            address_q <= {ptr_q, 1'b0};
            be_q      <= 2'b11;
            if (op_q == op_sti) begin
              write_q  <= 1'b1;
              dwdata_q <= wdata_q;
            end else begin
              read_q <= 1'b1;
            end
          end else if (dmem.dmem_resp) begin
            read_q  <= 1'b0;
            write_q <= 1'b0;
            state_q <= DONE;
            done_q  <= 1'b1;
            if (op_q == op_ldi) result_q <= dmem.dmem_rdata;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dmem.dmem_read        = read_q;
  assign dmem.dmem_write       = write_q;
  assign dmem.dmem_address     = address_q;
  assign dmem.dmem_wdata       = dwdata_q;
  assign dmem.dmem_byte_enable = be_q;
  assign done                  = done_q;
  assign result                = result_q;

endmodule

// File: tb/tb_dmem_access_seq.sv
module tb_dmem_access_seq;
  import dmem_access_seq_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       req_valid;
  lc3b_opcode req_opcode;
  lc3b_word   req_addr, req_wdata;
  logic       mem_stall, done;
  lc3b_word   result;

  dmem_access_seq_if bus ();

  logic     model_resp  = 1'b0;
  logic     stray_resp  = 1'b0;
  lc3b_word model_rdata = '0;
  assign bus.dmem_resp  = model_resp | stray_resp;
  assign bus.dmem_rdata = model_rdata;

  dmem_access_seq #(.DW(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_opcode (req_opcode),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .dmem       (bus),
    .mem_stall  (mem_stall),
    .done       (done),
    .result     (result)
  );

  typedef struct {
    logic       we;
    lc3b_word   addr;
    lc3b_word   wdata;
    logic [1:0] be;
    lc3b_word   rdata;
    int         lat;
  } acc_t;

  acc_t     exp_acc[$];
  lc3b_word exp_res[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_rd(input lc3b_word addr, input lc3b_word rdata, input int lat);
    exp_acc.push_back('{we: 1'b0, addr: addr, wdata: 16'h0, be: 2'b11, rdata: rdata, lat: lat});
  endtask

  task automatic push_wr(input lc3b_word addr, input lc3b_word wdata, input logic [1:0] be,
                         input int lat);
    exp_acc.push_back('{we: 1'b1, addr: addr, wdata: wdata, be: be, rdata: 16'h0, lat: lat});
  endtask

  // Memory model: checks each new request against the expected access and answers
  // after its latency; also checks the request is held exactly until the response.
  initial begin : responder
    acc_t cur;
    int   cnt;
    logic busy;
    busy = 1'b0;
    cnt  = 0;
    cur  = '{we: 1'b0, addr: 16'h0, wdata: 16'h0, be: 2'b11, rdata: 16'h0, lat: 1};
    forever begin
      @(negedge clk);
      #1;
      if (bus.dmem_read || bus.dmem_write) begin
        if (!busy) begin
          busy = 1'b1;
          cnt  = 0;
          if (exp_acc.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_access: addr %0h read %0b write %0b", bus.dmem_address,
                     bus.dmem_read, bus.dmem_write);
            cur = '{we: bus.dmem_write, addr: 16'h0, wdata: 16'h0, be: 2'b11, rdata: 16'h0,
                    lat: 1};
          end else begin
            cur = exp_acc.pop_front();
            check("acc_write", {31'b0, bus.dmem_write}, {31'b0, cur.we});
            check("acc_read", {31'b0, bus.dmem_read}, {31'b0, ~cur.we});
            check("acc_addr", {16'b0, bus.dmem_address}, {16'b0, cur.addr});
            check("acc_be", {30'b0, bus.dmem_byte_enable}, {30'b0, cur.be});
            if (cur.we) check("acc_wdata", {16'b0, bus.dmem_wdata}, {16'b0, cur.wdata});
          end
        end
        cnt++;
        model_resp  = (cnt >= cur.lat);
        model_rdata = cur.rdata;
      end else begin
        if (busy && rst_n) check("req_held_cycles", cnt, cur.lat);
        busy       = 1'b0;
        model_resp = 1'b0;
      end
    end
  end

  // Result monitor: pops the scoreboard on every done pulse.
  initial begin : monitor
    forever begin
      @(negedge clk);
      #3;
      check("rw_exclusive", {31'b0, bus.dmem_read & bus.dmem_write}, 32'd0);
      if (done) begin
        if (exp_res.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: result %0h", result);
        end else begin
          check("result", {16'b0, result}, {16'b0, exp_res.pop_front()});
        end
      end
    end
  end

  // Issue one op at a negedge, then count cycles until the stall drops (DONE cycle).
  task automatic do_op(input lc3b_opcode op, input lc3b_word addr, input lc3b_word wdata,
                       input int exp_cycles, input string name);
    int n;
    req_valid  = 1'b1;
    req_opcode = op;
    req_addr   = addr;
    req_wdata  = wdata;
    #1;
    check({name, "_stall_accept"}, {31'b0, mem_stall}, 32'd1);
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      #1;
      if (!mem_stall || n > 100) break;
    end
    check({name, "_latency"}, n, exp_cycles);
    check({name, "_done"}, {31'b0, done}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  initial begin : driver
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_opcode = op_add;
    req_addr   = '0;
    req_wdata  = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_read", {31'b0, bus.dmem_read}, 32'd0);
    check("rst_write", {31'b0, bus.dmem_write}, 32'd0);
    check("rst_address", {16'b0, bus.dmem_address}, 32'd0);
    check("rst_wdata", {16'b0, bus.dmem_wdata}, 32'd0);
    check("rst_be", {30'b0, bus.dmem_byte_enable}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_result", {16'b0, result}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    push_rd(16'h3004, 16'hBEEF, 3);
    exp_res.push_back(16'hBEEF);
    do_op(op_ldr, 16'h3005, 16'h0, 4, "ldr");

    push_rd(16'h2000, 16'hA55A, 2);
    exp_res.push_back(16'h00A5);
    do_op(op_ldb, 16'h2001, 16'h0, 3, "ldb_hi");

    push_rd(16'h2000, 16'hA55A, 1);
    exp_res.push_back(16'h005A);
    do_op(op_ldb, 16'h2000, 16'h0, 2, "ldb_lo");

    push_wr(16'h4000, 16'h3434, 2'b10, 2);
    exp_res.push_back(16'h005A);
    do_op(op_stb, 16'h4001, 16'h1234, 3, "stb_hi");

    push_wr(16'h4002, 16'h3434, 2'b01, 1);
    exp_res.push_back(16'h005A);
    do_op(op_stb, 16'h4002, 16'h1234, 2, "stb_lo");

    push_wr(16'h5002, 16'hABCD, 2'b11, 1);
    exp_res.push_back(16'h005A);
    do_op(op_str, 16'h5003, 16'hABCD, 2, "str");

    push_rd(16'h0040, 16'h1234, 1);
    exp_res.push_back(16'h1234);
    do_op(op_trap, 16'h0040, 16'h0, 2, "trap");

    push_rd(16'h1000, 16'h6003, 2);
    push_rd(16'h6002, 16'h0042, 1);
    exp_res.push_back(16'h0042);
    do_op(op_ldi, 16'h1000, 16'h0, 5, "ldi");

    push_rd(16'h1000, 16'h7000, 1);
    push_wr(16'h7000, 16'hCAFE, 2'b11, 2);
    exp_res.push_back(16'h0042);
    do_op(op_sti, 16'h1000, 16'hCAFE, 5, "sti");

    // Non-memory op: no access, no stall.
    req_valid  = 1'b1;
    req_opcode = op_add;
    req_addr   = 16'h3000;
    #1;
    check("add_stall", {31'b0, mem_stall}, 32'd0);
    repeat (3) begin
      @(negedge clk);
      #1;
      check("add_read", {31'b0, bus.dmem_read}, 32'd0);
      check("add_write", {31'b0, bus.dmem_write}, 32'd0);
      check("add_stall_hold", {31'b0, mem_stall}, 32'd0);
    end
    @(negedge clk);
    req_valid = 1'b0;

    // Reset while the second LDI read is outstanding.
    push_rd(16'h1000, 16'h6003, 1);
    push_rd(16'h6002, 16'h1111, 10);
    req_valid  = 1'b1;
    req_opcode = op_ldi;
    req_addr   = 16'h1000;
    repeat (3) @(negedge clk);
    #1;
    check("ldi_acc2_read", {31'b0, bus.dmem_read}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    check("abort_read", {31'b0, bus.dmem_read}, 32'd0);
    check("abort_write", {31'b0, bus.dmem_write}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_result", {16'b0, result}, 32'd0);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Stray response in IDLE must not produce done.
    stray_resp = 1'b1;
    @(negedge clk);
    stray_resp = 1'b0;
    #1;
    check("stray_done", {31'b0, done}, 32'd0);
    @(negedge clk);
    #1;
    check("stray_done_late", {31'b0, done}, 32'd0);

    // Back in IDLE: a fresh load runs normally.
    @(negedge clk);
    push_rd(16'h3004, 16'h5555, 1);
    exp_res.push_back(16'h5555);
    do_op(op_ldr, 16'h3004, 16'h0, 2, "ldr_after_rst");

    repeat (3) @(negedge clk);
    check("acc_queue_empty", exp_acc.size(), 32'd0);
    check("res_queue_empty", exp_res.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
